gpu_alu_sequencer: RTL and testbench
====================================

// Module: gpu_alu_sequencer
// PURPOSE
//  Single-issue execute stage sitting directly upstream of the GPU register file.
//  Accepts 16-bit instructions over a valid/ready handshake.
//  Reads up to two source operands through the register file's single combinational read port, one per cycle.
//  Computes the ALU result and drives the register file write port for one cycle.
// PARAMETERS
//  D_WIDTH   16  register/data width
//  A_WIDTH   4   register address width (instruction fields are 4 bits; A_WIDTH must be 4)
//  RF_DEPTH  4   number of implemented registers; addresses >= RF_DEPTH are illegal
// PORTS
//  clk              in   1        rising-edge clock
//  rst_n            in   1        asynchronous, active-low reset
//  instr            in   16       {op[15:12], rd[11:8], rs1[7:4], rs2[3:0]}; imm8 = instr[7:0]
//  instr_valid      in   1        instr is valid
//  instr_ready      out  1        block can accept an instruction
//  rf_read_addr     out  A_WIDTH  register file read address
//  rf_read_data     in   D_WIDTH  register file read data (combinational, same cycle)
//  rf_write_addr    out  A_WIDTH  register file write address
//  rf_write_data    out  D_WIDTH  register file write data
//  rf_write_enable  out  1        register file write strobe
//  done             out  1        one-cycle pulse when an instruction retires
//  err_illegal      out  1        one-cycle pulse, coincident with done, for an illegal instruction
//  flag_zero        out  1        result==0, updated at retire of ADD/SUB/AND/OR/XOR/SHL/SHR
//  flag_carry       out  1        ADD carry-out / SUB borrow; cleared by other ALU ops
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0, instr_ready included; op_a/op_b/instr latches 0.
//    instr_ready rises in the first cycle after rst_n deasserts.
//  - Reset asserted mid-instruction aborts it: no write, no done.
//  - States: IDLE, RD_A, RD_B, WB. instr_ready = (state==IDLE).
//    Accept = instr_valid & instr_ready; instr is latched on the accept edge.
//  - IDLE->RD_A on accept (ops 1-7, 9). IDLE->WB on accept (ops 0, 8, illegal).
//  - RD_A: rf_read_addr=rs1; op_a<=rf_read_data. Next state RD_B, or WB for MOV.
//  - RD_B: rf_read_addr=rs2; op_b<=rf_read_data. Next state WB.
//  - WB: rf_write_enable=1 (not for NOP or illegal), rf_write_addr=rd, rf_write_data=result.
//    done=1, then state returns to IDLE.
//  - Latency from accept edge to write cycle: 3 cycles for two-source ops, 2 for MOV, 1 for LDI/NOP.
//    Back-to-back issue: next accept is possible the cycle after WB.
//  - rf_read_addr holds its last value in IDLE/WB. rf_write_addr/data are 0 when rf_write_enable=0.
//  - Opcodes:
//    0 NOP; 1 ADD a+b; 2 SUB a-b; 3 AND; 4 OR; 5 XOR;
//    6 SHL a<<b[3:0]; 7 SHR a>>b[3:0] (logical); 8 LDI rd<=sign-extend(imm8); 9 MOV rd<=a;
//    10-15 illegal.
//  - Illegal also: any used register field (rd; rs1/rs2 when read) >= RF_DEPTH.
//    An illegal instruction takes the IDLE->WB path with no reads, no write, and pulses err_illegal.
//  - Arithmetic is modulo 2^D_WIDTH. carry = bit D_WIDTH of the (D_WIDTH+1)-bit sum/difference.
//  - Flags hold their value across NOP, LDI, MOV and illegal instructions.
//  - No combinational path from instr/instr_valid to any output; outputs depend on state and latches only.
//  - rd may equal rs1/rs2: operands are captured before WB, so the old value is used.
// TESTING
//  - Reset: hold rst_n=0 with instr_valid=1 -> instr_ready=0, no write.
//    Release -> instr_ready=1 next cycle.
//  - r1=0x0003, r2=0xFFFF; ADD r3,r1,r2 (0x1312) -> write r3=0x0002 exactly 3 cycles after accept;
//    flag_carry=1, flag_zero=0, done pulse.
//  - LDI r0,0x80 (0x8080) -> write r0=0xFF80 1 cycle after accept.
//    Then SUB r0,r0,r0 -> r0=0x0000, zero=1, carry=0.
//  - Opcode 0xB (0xB123), and ADD with rd=5 (RF_DEPTH=4) -> err_illegal+done, rf_write_enable never high.
//  - Hold instr_valid=1 with four ADDs -> accepts exactly every 4th cycle; instr_ready low in RD_A/RD_B/WB.
//  - Assert rst_n=0 during RD_B of an ADD -> no write ever occurs, block in IDLE after release.

Source files
------------

// File: rtl/gpu_alu_sequencer_if.sv
// Instruction handshake plus register-file port bundle for the ALU sequencer.
// Handshake: an instruction transfers on a rising edge where instr_valid and instr_ready are both high;
// instr_ready never depends on instr_valid, and the master holds instr stable while valid is high and not yet accepted.
interface gpu_alu_sequencer_if #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 4
);
    logic [15:0]        instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [A_WIDTH-1:0] rf_read_addr;
    logic [D_WIDTH-1:0] rf_read_data;
    logic [A_WIDTH-1:0] rf_write_addr;
    logic [D_WIDTH-1:0] rf_write_data;
    logic               rf_write_enable;
    logic               done;
    logic               err_illegal;
    logic               flag_zero;
    logic               flag_carry;

    modport slave (
        input  instr, instr_valid, rf_read_data,
        output instr_ready, rf_read_addr, rf_write_addr, rf_write_data, rf_write_enable,
        output done, err_illegal, flag_zero, flag_carry
    );

    modport master (
        output instr, instr_valid, rf_read_data,
        input  instr_ready, rf_read_addr, rf_write_addr, rf_write_data, rf_write_enable,
        input  done, err_illegal, flag_zero, flag_carry
    );
endinterface

// File: rtl/gpu_alu_sequencer.sv
// Single-issue execute stage: reads up to two operands through one RF read port, one per cycle,
// then writes the ALU result back in a one-cycle WB state.
module gpu_alu_sequencer #(
    parameter int D_WIDTH  = 16,
    parameter int A_WIDTH  = 4,
    parameter int RF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gpu_alu_sequencer_if.slave bus,
    output logic [1:0]         dbg_state_o
);
    typedef enum logic [1:0] {S_IDLE, S_RD_A, S_RD_B, S_WB} state_e;

    localparam logic [4:0] RF_LIM = 5'(RF_DEPTH);

    state_e             state_q, state_d;
    logic [15:0]        instr_q;
    logic [D_WIDTH-1:0] op_a_q, op_b_q;
    logic [A_WIDTH-1:0] raddr_q;
    logic               flag_zero_q, flag_carry_q;
    logic               live_q;

    logic               accept;
    logic               ready_c, we_c, done_c, err_c, flag_upd_c;
    logic [A_WIDTH-1:0] raddr_c, waddr_c;
    logic [D_WIDTH-1:0] wdata_c, result_c;
    logic               carry_c, wb_illegal;
    logic [3:0]         op_q;
    logic [D_WIDTH:0]   sum_c, diff_c;

    // Only register fields the opcode actually uses can make an instruction illegal.
    function automatic logic illegal_f(input logic [15:0] ins);
        logic bad_rd, bad_rs1, bad_rs2;
        bad_rd  = {1'b0, ins[11:8]} >= RF_LIM;
        bad_rs1 = {1'b0, ins[7:4]}  >= RF_LIM;
        bad_rs2 = {1'b0, ins[3:0]}  >= RF_LIM;
        illegal_f = 1'b0;
        if (ins[15:12] >= 4'd10)                               illegal_f = 1'b1;
        else if (ins[15:12] >= 4'd1 && ins[15:12] <= 4'd7)     illegal_f = bad_rd | bad_rs1 | bad_rs2;
        else if (ins[15:12] == 4'd8)                           illegal_f = bad_rd;
        else if (ins[15:12] == 4'd9)                           illegal_f = bad_rd | bad_rs1;
    endfunction

    function automatic logic needs_read_f(input logic [15:0] ins);
        needs_read_f = !illegal_f(ins) &&
                       ((ins[15:12] >= 4'd1 && ins[15:12] <= 4'd7) || ins[15:12] == 4'd9);
    endfunction

    assign op_q       = instr_q[15:12];
    assign wb_illegal = illegal_f(instr_q);
    assign sum_c      = {1'b0, op_a_q} + {1'b0, op_b_q};
    assign diff_c     = {1'b0, op_a_q} - {1'b0, op_b_q};

    always_comb begin
        result_c = '0;
        carry_c  = 1'b0;
        case (op_q)
            4'd1: begin result_c = sum_c[D_WIDTH-1:0];  carry_c = sum_c[D_WIDTH];  end
            4'd2: begin result_c = diff_c[D_WIDTH-1:0]; carry_c = diff_c[D_WIDTH]; end
            4'd3: result_c = op_a_q & op_b_q;
            4'd4: result_c = op_a_q | op_b_q;
            4'd5: result_c = op_a_q ^ op_b_q;
            4'd6: result_c = op_a_q << op_b_q[3:0];
            4'd7: result_c = op_a_q >> op_b_q[3:0];
            4'd8: result_c = {{(D_WIDTH-8){instr_q[7]}}, instr_q[7:0]};
            4'd9: result_c = op_a_q;
            default: result_c = '0;
        endcase
    end

    // live_q keeps instr_ready low until the first edge after reset release.
    assign accept = bus.instr_valid & live_q & (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        ready_c    = 1'b0;
        raddr_c    = raddr_q;
        we_c       = 1'b0;
        waddr_c    = '0;
        wdata_c    = '0;
        done_c     = 1'b0;
        err_c      = 1'b0;
        flag_upd_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_c = live_q;
                if (accept) state_d = needs_read_f(bus.instr) ? S_RD_A : S_WB;
            end
            S_RD_A: begin
                raddr_c = A_WIDTH'(instr_q[7:4]);
                state_d = (op_q == 4'd9) ? S_WB : S_RD_B;
            end
            S_RD_B: begin
                raddr_c = A_WIDTH'(instr_q[3:0]);
                state_d = S_WB;
            end
            S_WB: begin
                done_c = 1'b1;
                err_c  = wb_illegal;
                if (!wb_illegal && op_q != 4'd0) begin
                    we_c    = 1'b1;
                    waddr_c = A_WIDTH'(instr_q[11:8]);
                    wdata_c = result_c;
                end
                flag_upd_c = !wb_illegal && op_q >= 4'd1 && op_q <= 4'd7;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            raddr_q      <= '0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
            live_q       <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            raddr_q <= raddr_c;
            if (accept)              instr_q <= bus.instr;
            if (state_q == S_RD_A)   op_a_q  <= bus.rf_read_data;
            if (state_q == S_RD_B)   op_b_q  <= bus.rf_read_data;
            if (flag_upd_c) begin
                flag_zero_q  <= (result_c == '0);
                flag_carry_q <= carry_c;
            end
        end
    end

    assign bus.instr_ready     = ready_c;
    assign bus.rf_read_addr    = raddr_c;
    assign bus.rf_write_enable = we_c;
    assign bus.rf_write_addr   = waddr_c;
    assign bus.rf_write_data   = wdata_c;
    assign bus.done            = done_c;
    assign bus.err_illegal     = err_c;
    assign bus.flag_zero       = flag_zero_q;
    assign bus.flag_carry      = flag_carry_q;
    assign dbg_state_o         = state_q;
endmodule

// File: tb/tb_gpu_alu_sequencer.sv
// Bench for gpu_alu_sequencer: a register file array behind the read/write ports and an
// instruction-level reference model that predicts every write, retire latency and flag value.
module tb_gpu_alu_sequencer;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    gpu_alu_sequencer_if #(.D_WIDTH(16), .A_WIDTH(4)) bus ();

    gpu_alu_sequencer #(.D_WIDTH(16), .A_WIDTH(4), .RF_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file seen by the DUT
    logic [15:0] rf [4];
    assign bus.rf_read_data = (bus.rf_read_addr < 4'd4) ? rf[bus.rf_read_addr[1:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (bus.rf_write_enable && bus.rf_write_addr < 4'd4)
            rf[bus.rf_write_addr[1:0]] <= bus.rf_write_data;
    end

    // reference model state and scoreboard
    logic [15:0] mdl [4];
    bit          mdl_zero;
    bit          mdl_carry;
    logic [19:0] exp_q[$];
    int          n_vec;
    int          n_err;
    int          n_writes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Executes one instruction at ISA level; pushes the predicted write onto exp_q.
    task automatic model_exec(input logic [15:0] ins, output int lat, output bit ill, output bit we);
        int op, rd, rs1, rs2, a, b;
        bit two_src, one_src, writes, alu;
        logic [15:0] res;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:8]);
        rs1 = int'(ins[7:4]);
        rs2 = int'(ins[3:0]);
        two_src = (op >= 1 && op <= 7);
        one_src = (op == 9);
        writes  = (op >= 1 && op <= 9);
        alu     = two_src;
        ill = (op >= 10) || (writes && rd >= 4) || ((two_src || one_src) && rs1 >= 4) ||
              (two_src && rs2 >= 4);
        lat = (ill || op == 0 || op == 8) ? 1 : (op == 9 ? 2 : 3);
        we  = !ill && writes;
        if (!we) return;
        a = (two_src || one_src) ? int'(mdl[rs1]) : 0;
        b = two_src ? int'(mdl[rs2]) : 0;
        res = 16'h0;
        case (op)
            1: begin res = 16'(a + b); mdl_carry = (a + b) > 65535; end
            2: begin res = 16'(a - b); mdl_carry = (a < b); end
            3: res = 16'(a & b);
            4: res = 16'(a | b);
            5: res = 16'(a ^ b);
            6: res = 16'(a << (b % 16));
            7: res = 16'(a >> (b % 16));
            8: res = 16'($signed(ins[7:0]));
            9: res = 16'(a);
            default: res = 16'h0;
        endcase
        if (alu) begin
            mdl_zero = (res == 16'h0);
            if (op > 2) mdl_carry = 1'b0;
        end
        mdl[rd] = res;
        exp_q.push_back({ins[11:8], res});
    endtask

    // write monitor
    always @(negedge clk) begin
        if (bus.rf_write_enable) begin
            logic [19:0] e;
            n_writes++;
            check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.rf_write_addr), 32'(e[19:16]));
                check("wr_data", 32'(bus.rf_write_data), 32'(e[15:0]));
            end
        end
    end

    // driver: issue one instruction and check its retire
    task automatic run_instr(input logic [15:0] ins);
        int lat, k;
        bit ill, we, acc;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 10 && !acc; c++) begin
            @(negedge clk);
            acc = bus.instr_ready;
            @(posedge clk); #1;
        end
        bus.instr_valid = 1'b0;
        bus.instr       = 16'($urandom);
        check("accept", 32'(acc), 32'd1);
        if (!acc) return;
        model_exec(ins, lat, ill, we);
        for (k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("busy_ready", 32'(bus.instr_ready), 32'd0);
            if (bus.done) break;
        end
        check("latency", 32'(k), 32'(lat));
        if (k <= 6) begin
            check("err_illegal", 32'(bus.err_illegal), 32'(ill));
            check("write_en", 32'(bus.rf_write_enable), 32'(we));
        end
        @(posedge clk); #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("flag_zero", 32'(bus.flag_zero), 32'(mdl_zero));
        check("flag_carry", 32'(bus.flag_carry), 32'(mdl_carry));
    endtask

    function automatic logic [3:0] rand_reg();
        if ($urandom_range(0, 9) == 0) return 4'($urandom_range(4, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] b2b [4];
        logic [15:0] ins;
        int k, w0, lat;
        bit ill, we;
        n_vec = 0; n_err = 0; n_writes = 0;
        mdl_zero = 1'b0; mdl_carry = 1'b0;

        // reset with a pending instruction
        rst_n = 1'b0;
        bus.instr       = 16'h1312;
        bus.instr_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 32'(bus.instr_ready), 32'd0);
            check("rst_we", 32'(bus.rf_write_enable), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
        end
        check("rst_err", 32'(bus.err_illegal), 32'd0);
        check("rst_flags", 32'({bus.flag_zero, bus.flag_carry}), 32'd0);
        check("rst_raddr", 32'(bus.rf_read_addr), 32'd0);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready_early", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        check("rel_ready", 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;

        // seed every register with LDI
        for (int r = 0; r < 4; r++) run_instr({4'h8, 4'(r), 8'($urandom)});

        // directed ADD with carry-out
        run_instr(16'h8103);
        run_instr(16'h82FF);
        run_instr(16'h1312);
        check("add_carry", 32'(bus.flag_carry), 32'd1);
        check("add_zero", 32'(bus.flag_zero), 32'd0);
        check("raddr_hold", 32'(bus.rf_read_addr), 32'd2);

        // LDI sign extension then SUB to zero
        run_instr(16'h8080);
        run_instr(16'h2000);
        check("sub_zero", 32'(bus.flag_zero), 32'd1);
        check("sub_carry", 32'(bus.flag_carry), 32'd0);

        // illegal opcode and out-of-range rd
        w0 = n_writes;
        run_instr(16'hB123);
        run_instr(16'h1512);
        check("illegal_no_write", 32'(n_writes), 32'(w0));

        // randomized instruction mix
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) ins[15:12] = 4'($urandom_range(0, 15));
            else                           ins[15:12] = 4'($urandom_range(0, 9));
            ins[11:8] = rand_reg();
            ins[7:4]  = rand_reg();
            ins[3:0]  = rand_reg();
            run_instr(ins);
        end

        // back-to-back ADDs with valid held high
        b2b[0] = 16'h1112;
        for (int i = 1; i < 4; i++)
            b2b[i] = {4'h1, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        k = 0;
        bus.instr       = b2b[0];
        bus.instr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check("b2b_ready", 32'(bus.instr_ready), 32'(c % 4 == 0));
            if (bus.instr_ready && bus.instr_valid) begin
                model_exec(bus.instr, lat, ill, we);
                k++;
            end
            @(posedge clk); #1;
            if (k < 4) bus.instr = b2b[k];
            else       bus.instr_valid = 1'b0;
        end
        check("b2b_accepts", 32'(k), 32'd4);
        check("b2b_zero", 32'(bus.flag_zero), 32'(mdl_zero));
        check("b2b_carry", 32'(bus.flag_carry), 32'(mdl_carry));

        // reset during RD_B aborts the ADD
        bus.instr       = 16'h1312;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        w0 = n_writes;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ready_rst", 32'(bus.instr_ready), 32'd0);
        check("abort_we_rst", 32'(bus.rf_write_enable), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mdl_zero = 1'b0;
        mdl_carry = 1'b0;
        @(negedge clk);
        check("abort_ready_early", 32'(bus.instr_ready), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_no_write", 32'(n_writes), 32'(w0));
        check("abort_idle_ready", 32'(bus.instr_ready), 32'd1);
        check("abort_no_done", 32'(bus.done), 32'd0);
        check("abort_flags", 32'({bus.flag_zero, bus.flag_carry}), 32'({mdl_zero, mdl_carry}));

        // one more instruction after the abort must still work
        @(posedge clk); #1;
        run_instr(16'h9310);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
